// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencing. Drives the branch-target LUT address
// from the instruction index field, resolves taken branches in the same cycle
// from the returned LUT value, and provides start/done run control plus a
// saturating retired-instruction counter.
module pc_fetch_ctrl #(
   parameter int                PC_W     = 10,
   parameter int                LUT_AW   = 5,
   parameter int                LUT_DW   = 8,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              branch_en,
   input  logic              branch_cond,
   input  logic              branch_abs,
   input  logic [LUT_AW-1:0] lut_idx,
   output logic [LUT_AW-1:0] lut_addr,
   input  logic [LUT_DW-1:0] lut_data,
   output logic [PC_W-1:0]   pc,
   output logic              running,
   output logic              done,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state;
   logic             taken;
   logic [CNT_W-1:0] cnt_inc;

   // The LUT is combinational, so the target comes back in the same cycle.
   assign lut_addr = lut_idx;
   assign taken    = branch_en & branch_cond;

   // Counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (&instr_count) ? instr_count : instr_count + CNT_W'(1);

   // Run-control FSM; pc, counter and status flags are all registered here.
   // lut_data is only looked at inside the taken-branch arm, so an unknown
   // LUT output on other cycles never reaches state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr_count <= '0;
         running     <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_RUN;
                  pc          <= RESET_PC;
                  instr_count <= '0;
                  running     <= 1'b1;
                  done        <= 1'b0;
               end
            end
            ST_RUN: begin
               if (start) begin
                  // restart in place
                  pc          <= RESET_PC;
                  instr_count <= '0;
               end else if (stall) begin
                  // stall masks halt and branch for this cycle
               end else if (halt_req) begin
                  // pc stays on the halt instruction; the halt itself retires
                  state       <= ST_HALT;
                  instr_count <= cnt_inc;
                  running     <= 1'b0;
                  done        <= 1'b1;
               end else if (taken) begin
                  if (branch_abs)
                     pc <= PC_W'(lut_data);
                  else
                     pc <= pc + PC_W'($signed(lut_data));
                  instr_count <= cnt_inc;
               end else begin
                  pc          <= pc + PC_W'(1);
                  instr_count <= cnt_inc;
               end
            end
            ST_HALT: begin
               if (start) begin
                  state       <= ST_RUN;
                  pc          <= RESET_PC;
                  instr_count <= '0;
                  running     <= 1'b1;
                  done        <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               pc      <= RESET_PC;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed walk through the fetch scenarios, then
// randomized instruction streams against an arithmetic reference model.
// A second instance with a 4-bit counter shares all stimulus so counter
// saturation is exercised continuously.
module tb_pc_fetch_ctrl;

   localparam int PC_W   = 10;
   localparam int LUT_AW = 5;
   localparam int LUT_DW = 8;
   localparam int PC_MOD = 1 << PC_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start, stall, halt_req, branch_en, branch_cond, branch_abs;
   logic [LUT_AW-1:0] lut_idx;
   logic [LUT_AW-1:0] lut_addr, lut_addr_s;
   logic [LUT_DW-1:0] lut_data, lut_data_s;
   logic [PC_W-1:0]   pc, pc_s;
   logic              running, done, running_s, done_s;
   logic [15:0]       instr_count;
   logic [3:0]        instr_count_s;

   logic [LUT_DW-1:0] lut_mem [32];

   int n_cmp = 0;
   int n_err = 0;

   // reference model: mode 0 idle, 1 run, 2 halt; count kept unbounded
   int m_mode, m_pc, m_cnt;

   always #5 clk = ~clk;

   assign lut_data   = lut_mem[lut_addr];
   assign lut_data_s = lut_mem[lut_addr_s];

   pc_fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .LUT_DW(LUT_DW), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_cond(branch_cond), .branch_abs(branch_abs),
      .lut_idx(lut_idx), .lut_addr(lut_addr), .lut_data(lut_data), .pc(pc),
      .running(running), .done(done), .instr_count(instr_count));

   pc_fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .LUT_DW(LUT_DW), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_cond(branch_cond), .branch_abs(branch_abs),
      .lut_idx(lut_idx), .lut_addr(lut_addr_s), .lut_data(lut_data_s), .pc(pc_s),
      .running(running_s), .done(done_s), .instr_count(instr_count_s));

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Compare every output of both instances against the model.
   task automatic chk_all(input string tag);
      chk({tag, ".pc"},      int'(pc),            m_pc);
      chk({tag, ".run"},     int'(running),       int'(m_mode == 1));
      chk({tag, ".done"},    int'(done),          int'(m_mode == 2));
      chk({tag, ".cnt"},     int'(instr_count),   min_i(m_cnt, 65535));
      chk({tag, ".pc_s"},    int'(pc_s),          m_pc);
      chk({tag, ".cnt_s"},   int'(instr_count_s), min_i(m_cnt, 15));
   endtask

   // Apply one instruction's inputs, check the LUT address, clock, then
   // advance the model and check all outputs.
   task automatic cyc(input bit st, input bit sl, input bit hl, input bit be,
                      input bit bc, input bit ba, input int idx);
      int data, off;
      start = st; stall = sl; halt_req = hl;
      branch_en = be; branch_cond = bc; branch_abs = ba;
      lut_idx = LUT_AW'(idx);
      #1;
      chk("lut_addr", int'(lut_addr), idx);
      data = int'(lut_mem[idx]);
      @(posedge clk);
      #1;
      if (st) begin
         m_mode = 1; m_pc = 0; m_cnt = 0;
      end else if (m_mode == 1 && !sl) begin
         m_cnt++;
         if (hl)
            m_mode = 2;
         else if (be && bc && ba)
            m_pc = data;
         else if (be && bc) begin
            off  = (data >= 128) ? data - 256 : data;
            m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
         end else
            m_pc = (m_pc + 1) % PC_MOD;
      end
      chk_all("cyc");
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, $urandom_range(0, 31));
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      m_mode = 0; m_pc = 0; m_cnt = 0;
      chk_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_rst");
   endtask

   initial begin
      reset = 1'b1;
      start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_cond = 0; branch_abs = 0;
      lut_idx = '0;
      for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom);
      m_mode = 0; m_pc = 0; m_cnt = 0;
      #12;
      chk_all("reset");
      reset = 1'b0;

      // idle ignores everything but start
      cyc(0, 0, 1, 1, 1, 1, 3);
      chk("idle_pc", int'(pc), 0);

      // 1: start and five sequential instructions
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(5);
      chk("seq_pc", int'(pc), 5);
      chk("seq_cnt", int'(instr_count), 5);
      chk("seq_run", int'({running, done}), 2);

      // 2: absolute branch at pc=3, then not-taken at pc=3
      lut_mem[7] = 8'h40;
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(3);
      cyc(0, 0, 0, 1, 1, 1, 7);
      chk("abs_pc", int'(pc), 64);
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(3);
      cyc(0, 0, 0, 1, 0, 1, 7);
      chk("nt_pc", int'(pc), 4);

      // 3: relative branches and wrap
      lut_mem[2] = 8'hFB;
      lut_mem[9] = 8'hFD;
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(10);
      cyc(0, 0, 0, 1, 1, 0, 2);
      chk("rel_back", int'(pc), 5);
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(1);
      cyc(0, 0, 0, 1, 1, 0, 9);
      chk("rel_wrap", int'(pc), 1022);
      plain(1);
      chk("pc_1023", int'(pc), 1023);
      plain(1);
      chk("pc_wrap0", int'(pc), 0);

      // 4: stall masks halt and branch, then halt retires
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(6);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 1, 1, 1, 7);
         chk("stall_pc", int'(pc), 6);
         chk("stall_cnt", int'(instr_count), 6);
      end
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("halt_done", int'({running, done}), 1);
      chk("halt_pc", int'(pc), 6);
      chk("halt_cnt", int'(instr_count), 7);
      cyc(0, 0, 0, 1, 1, 1, 7);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("halt_frozen", int'(pc), 6);

      // 5: restart from HALT and mid-RUN
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("restart_run", int'({running, done}), 2);
      chk("restart_cnt", int'(instr_count), 0);
      plain(20);
      chk("pc20", int'(pc), 20);
      cyc(1, 0, 1, 1, 1, 1, 7);
      chk("midrun_start", int'(pc), 0);

      // 6: async reset at pc=37, then counter saturation
      plain(37);
      chk("pc37", int'(pc), 37);
      async_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
      plain(20);
      chk("sat4", int'(instr_count_s), 15);
      chk("cnt20", int'(instr_count), 20);

      // randomized streams
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) lut_mem[$urandom_range(0, 31)] = 8'($urandom);
         if ($urandom_range(0, 299) == 0)
            async_reset();
         else
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 31));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage for the processor core. It sits directly upstream of the 32-entry, 8-bit branch-target LUT. It drives the LUT address from the instruction's 5-bit index field and consumes the returned 8-bit value as an absolute target or a signed relative offset on taken branches. It also provides start/done run control and a retired-instruction counter for the top-level bench.

Parameters:
PC_W, 10, program counter width in bits; must be >= 8.
LUT_AW, 5, LUT address width.
LUT_DW, 8, LUT data width.
RESET_PC, 0, PC value loaded on reset and on every (re)start.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; begins or restarts program execution.
stall  input  1  freezes PC, counter and state while high (RUN only).
halt_req  input  1  current instruction is a halt.
branch_en  input  1  current instruction is a branch.
branch_cond  input  1  branch condition flag; branch is taken when branch_en && branch_cond.
branch_abs  input  1  1 = absolute target, 0 = PC-relative offset.
lut_idx  input  LUT_AW  index field of the current instruction.
lut_addr  output  LUT_AW  address to the branch LUT.
lut_data  input  LUT_DW  LUT output, combinational from lut_addr.
pc  output  PC_W  current instruction address (registered).
running  output  1  high in RUN.
done  output  1  high in HALT (level, not pulse).
instr_count  output  CNT_W  instructions retired since last start; saturating.

Behaviour:
- States: IDLE, RUN, HALT. Encoding is free.
- Reset (async assert; synchronous release behaviour is unaffected): state=IDLE, pc=RESET_PC, instr_count=0, running=0, done=0. Reset mid-RUN aborts immediately; there is no partial update.
- lut_addr = lut_idx, purely combinational, in every state. The LUT is combinational, so target data is used in the same cycle (0-cycle branch resolution).
- IDLE:
  - pc holds RESET_PC.
  - start -> RUN next edge; pc stays RESET_PC and instr_count clears to 0.
  - All other inputs are ignored.
- RUN, per rising edge, evaluated in this priority order:
  1. stall=1: hold pc, instr_count and state. stall also masks halt_req and branches that cycle.
  2. halt_req=1: -> HALT. pc holds (points at the halt instruction). instr_count increments; the halt counts as retired.
  3. Taken branch, absolute: pc <= zero-extend(lut_data) to PC_W.
  4. Taken branch, relative: pc <= pc + sign-extend(lut_data) to PC_W, modulo 2^PC_W (wraps both directions).
  5. Otherwise: pc <= pc + 1, modulo 2^PC_W (all-ones wraps to 0).
  - For cases 3-5, instr_count += 1, saturating at 2^CNT_W-1.
  - Branch with branch_cond=0 behaves as case 5.
  - start while in RUN: pc <= RESET_PC, instr_count <= 0, stays RUN. start has priority over everything except reset.
- HALT:
  - done=1, running=0; pc and instr_count frozen.
  - stall, branch and halt inputs are ignored.
  - start -> RUN with pc=RESET_PC, instr_count=0, done drops on the same edge.
- running and done are registered, derived from state, and never both high.
- No X propagation: lut_data is sampled only on taken branches. Otherwise it may be X without affecting state.

Test Plan:
1. Reset then start, no branches, 5 cycles -> pc sequence 0,1,2,3,4,5; instr_count=5; running=1, done=0.
2. At pc=3, lut_idx=7, lut_data=8'h40, branch_en=1, branch_cond=1, branch_abs=1 -> next pc=64, lut_addr=7. Repeat with branch_cond=0 -> pc=4.
3. Relative branch at pc=10: lut_data=8'hFB (-5) -> pc=5. At pc=1 with lut_data=8'hFD (-3) -> pc=1022 (wrap). At pc=1023 with no branch -> pc=0.
4. Assert stall for 3 cycles together with branch_en=1 and halt_req=1 at pc=6 -> pc stays 6 and instr_count is unchanged throughout. Deassert stall with halt_req=1 -> HALT, done=1, pc=6, instr_count incremented by 1.
5. In HALT pulse start -> next cycle running=1, done=0, pc=0, instr_count=0. Start mid-RUN at pc=20 -> pc=0 next edge.
6. Assert reset asynchronously mid-cycle in RUN at pc=37 -> outputs go to reset values before the next clock edge. Also, with CNT_W forced to 4, run 20 instructions -> instr_count saturates at 15.
